// File: rtl/tart_vis_reader.sv
// Drains one correlator bank over the read bus into the visibility buffer.
// Walks unit/pair/slot/ri in order, one transfer per request/gap pair.
module tart_vis_reader #(
  parameter int ABITS   = 14,
  parameter int BLOCK   = 24,
  parameter int UNITS   = 6,
  parameter int SLOTS   = 12,
  parameter int TIMEOUT = 31,
  parameter int DELAY   = 3
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             switch_i,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic             bst_o,
  output logic [ABITS-1:0] adr_o,
  input  logic             ack_i,
  input  logic             wat_i,
  input  logic             err_i,
  input  logic [BLOCK-1:0] dat_i,
  output logic             vis_we_o,
  output logic [9:0]       vis_adr_o,
  output logic [BLOCK-1:0] vis_dat_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ready_o,
  output logic             overrun_o,
  output logic             error_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // DELAY only shaped simulation timing in older models; no effect here.
  if (DELAY < 0) begin : g_delay_unused
  end

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       unit_q;
  logic [1:0]       pair_q;
  logic [3:0]       slot_q;
  logic             ri_q;
  logic [9:0]       idx_q;
  logic [TW-1:0]    tmo_q;
  logic [BLOCK-1:0] dat_q;
  logic             we_q, done_q, ready_q;
  logic             ovr_q, err_q;

  logic last, start, abort, take, fin, go;

  always_comb begin
    last  = (unit_q == 3'(UNITS - 1))
         && (pair_q == 2'd3)
         && (slot_q == 4'(SLOTS - 1))
         && ri_q;
    start = (state_q == IDLE)
         && switch_i && enable_i;
    abort = (state_q == REQ)
         && (err_i || (!ack_i && tmo_q == TW'(TIMEOUT)));
    take  = (state_q == REQ) && ack_i && !err_i;
    fin   = take && (last || !enable_i);
    go    = take && !fin;
    state_d = state_q;
    unique case (1'b1)
      start:            state_d = REQ;
      abort, fin:       state_d = IDLE;
      go:               state_d = GAP;
      (state_q == GAP): state_d = REQ;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      unit_q <= '0;
      pair_q <= '0;
      slot_q <= '0;
      ri_q   <= 1'b0;
      idx_q  <= '0;
      tmo_q  <= '0;
    end else if (start) begin
      unit_q <= '0;
      pair_q <= '0;
      slot_q <= '0;
      ri_q   <= 1'b0;
      idx_q  <= '0;
      tmo_q  <= '0;
    end else if (state_q == GAP) begin
      ri_q  <= ~ri_q;
      idx_q <= idx_q + 10'd1;
      tmo_q <= '0;
      if (ri_q) begin
        if (slot_q == 4'(SLOTS - 1)) begin
          slot_q <= '0;
          pair_q <= pair_q + 2'd1;
          if (pair_q == 2'd3)
            unit_q <= unit_q + 3'd1;
        end else begin
          slot_q <= slot_q + 4'd1;
        end
      end
    end else if (state_q == REQ && !wat_i) begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      dat_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      ovr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q   <= take;
      done_q <= take && last;
      if (take) dat_q <= dat_i;
      if (start)              ready_q <= 1'b0;
      else if (take && last)  ready_q <= 1'b1;
      if (start)      err_q <= 1'b0;
      else if (abort) err_q <= 1'b1;
      // overrun is only cleared by dropping enable
      if (!enable_i)
        ovr_q <= 1'b0;
      else if (switch_i && state_q != IDLE)
        ovr_q <= 1'b1;
    end
  end

  assign cyc_o     = (state_q != IDLE);
  assign stb_o     = (state_q == REQ);
  assign we_o      = 1'b0;
  assign bst_o     = cyc_o && !last;
  assign adr_o     = cyc_o
                   ? ABITS'({unit_q, pair_q, slot_q, ri_q})
                   : '0;
  assign busy_o    = cyc_o;
  assign vis_we_o  = we_q;
  assign vis_adr_o = idx_q;
  assign vis_dat_o = dat_q;
  assign done_o    = done_q;
  assign ready_o   = ready_q;
  assign overrun_o = ovr_q;
  assign error_o   = err_q;

endmodule

// File: tb/tb_tart_vis_reader.sv
// Bench for tart_vis_reader: randomized responder against an index model.
// Checks address order, buffer writes, flags, aborts and async reset.
module tb_tart_vis_reader;

  localparam int ABITS = 14;
  localparam int BLOCK = 24;
  localparam int NW    = 576;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_TMO  = 3;
  localparam int M_WAIT = 4;

  logic             clk_i    = 1'b0;
  logic             rst_n    = 1'b1;
  logic             enable_i = 1'b0;
  logic             switch_i = 1'b0;
  logic             ack_i    = 1'b0;
  logic             wat_i    = 1'b0;
  logic             err_i    = 1'b0;
  logic [BLOCK-1:0] dat_i    = '0;
  logic             cyc_o, stb_o, we_o, bst_o;
  logic [ABITS-1:0] adr_o;
  logic             vis_we_o;
  logic [9:0]       vis_adr_o;
  logic [BLOCK-1:0] vis_dat_o;
  logic             busy_o, done_o, ready_o;
  logic             overrun_o, error_o;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int bank_no  = 0;
  int wr_bank [1024];

  tart_vis_reader dut (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .enable_i  (enable_i),
    .switch_i  (switch_i),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .bst_o     (bst_o),
    .adr_o     (adr_o),
    .ack_i     (ack_i),
    .wat_i     (wat_i),
    .err_i     (err_i),
    .dat_i     (dat_i),
    .vis_we_o  (vis_we_o),
    .vis_adr_o (vis_adr_o),
    .vis_dat_o (vis_dat_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .ready_o   (ready_o),
    .overrun_o (overrun_o),
    .error_o   (error_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (vis_we_o) begin
      wr_cnt++;
      wr_bank[vis_adr_o] = bank_no;
    end
    if (done_o) done_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // word i -> bus address, from the unit/pair/slot/ri decomposition
  function automatic logic [31:0] exp_adr(input int i);
    int u, p, s, r;
    u = i / 96;
    p = (i % 96) / 24;
    s = (i % 24) / 2;
    r = i % 2;
    return 32'((u << 7) | (p << 5) | (s << 1) | r);
  endfunction

  task automatic start_bank();
    @(negedge clk_i);
    enable_i = 1'b1;
    switch_i = 1'b1;
    @(negedge clk_i);
    switch_i = 1'b0;
    check("start_cyc", cyc_o, 1);
    check("start_stb", stb_o, 1);
    check("start_adr", adr_o, 0);
    check("start_busy", busy_o, 1);
    check("start_ready", ready_o, 0);
    check("start_error", error_o, 0);
  endtask

  task automatic serve_word(input int i, input int mode,
                            input int lat, input bit sw,
                            output bit stop);
    int n;
    logic [BLOCK-1:0] d;
    stop = 1'b0;
    n = 0;
    while (!stb_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check($sformatf("stb_wait[%0d]", i), stb_o, 1);
    if (!stb_o) begin
      stop = 1'b1;
      return;
    end
    check($sformatf("adr[%0d]", i), adr_o, exp_adr(i));
    check($sformatf("bst[%0d]", i), bst_o, i != NW - 1);
    check($sformatf("we[%0d]", i), we_o, 0);
    if (sw) begin
      switch_i = 1'b1;
      @(negedge clk_i);
      switch_i = 1'b0;
      check("overrun_set", overrun_o, 1);
      check("overrun_stb", stb_o, 1);
    end
    repeat (lat) @(negedge clk_i);
    d = BLOCK'($urandom);
    case (mode)
      M_ERR, M_BOTH: begin
        err_i = 1'b1;
        ack_i = (mode == M_BOTH);
        dat_i = d;
        @(negedge clk_i);
        err_i = 1'b0;
        ack_i = 1'b0;
        check("abort_vis_we", vis_we_o, 0);
        check("abort_error", error_o, 1);
        check("abort_cyc", cyc_o, 0);
        check("abort_stb", stb_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        stop = 1'b1;
      end
      M_TMO: begin
        n = 0;
        while (cyc_o && n < 60) begin
          @(negedge clk_i);
          n++;
        end
        check("tmo_cycles", n, 32);
        check("tmo_error", error_o, 1);
        stop = 1'b1;
      end
      default: begin
        if (mode == M_WAIT) begin
          wat_i = 1'b1;
          n = 0;
          repeat (40) begin
            @(negedge clk_i);
            n += int'(cyc_o);
          end
          wat_i = 1'b0;
          check("wait_hold", n, 40);
        end
        ack_i = 1'b1;
        dat_i = d;
        @(negedge clk_i);
        ack_i = 1'b0;
        dat_i = '0;
        check($sformatf("vis_we[%0d]", i), vis_we_o, 1);
        check($sformatf("vis_adr[%0d]", i), vis_adr_o, i);
        check($sformatf("vis_dat[%0d]", i), vis_dat_o, d);
        check($sformatf("gap_stb[%0d]", i), stb_o, 0);
        if (i == NW - 1) begin
          check("last_done", done_o, 1);
          check("last_ready", ready_o, 1);
          check("last_cyc", cyc_o, 0);
          check("last_busy", busy_o, 0);
          stop = 1'b1;
        end else begin
          check($sformatf("gap_cyc[%0d]", i), cyc_o, 1);
          check($sformatf("gap_done[%0d]", i), done_o, 0);
          @(negedge clk_i);
          check($sformatf("gap1[%0d]", i), stb_o, 1);
        end
      end
    endcase
  endtask

  task automatic run_bank(input int stop_at, input int stop_mode,
                          input int sw_at, input int fix_lat,
                          output int writes, output int dones);
    int wb, db, mode, lat;
    bit stop;
    bank_no++;
    wb = wr_cnt;
    db = done_cnt;
    start_bank();
    for (int i = 0; i < NW; i++) begin
      mode = (i == stop_at) ? stop_mode : M_ACK;
      lat  = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
      if (mode == M_TMO || mode == M_WAIT) lat = 0;
      serve_word(i, mode, lat, i == sw_at, stop);
      if (stop) break;
    end
    repeat (3) begin
      @(negedge clk_i);
      check("no_restart", cyc_o, 0);
    end
    writes = wr_cnt - wb;
    dones  = done_cnt - db;
  endtask

  function automatic int bank_hits();
    int h = 0;
    for (int i = 0; i < NW; i++)
      if (wr_bank[i] == bank_no) h++;
    return h;
  endfunction

  initial begin
    int w, dn;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_outs",
          {cyc_o, stb_o, we_o, bst_o, busy_o, done_o,
           ready_o, overrun_o, error_o, vis_we_o}, 0);
    check("rst_adr", adr_o, 0);
    check("rst_vis_adr", vis_adr_o, 0);
    check("rst_vis_dat", vis_dat_o, 0);
    rst_n = 1'b1;

    switch_i = 1'b1;
    @(negedge clk_i);
    switch_i = 1'b0;
    @(negedge clk_i);
    check("sw_no_enable", cyc_o, 0);

    run_bank(-1, M_ACK, -1, 2, w, dn);
    check("full_writes", w, NW);
    check("full_done", dn, 1);
    check("full_idx", bank_hits(), NW);
    check("full_ready", ready_o, 1);
    check("full_error", error_o, 0);
    check("full_overrun", overrun_o, 0);

    run_bank(100, M_ERR, -1, -1, w, dn);
    check("err_writes", w, 100);
    check("err_idx100", wr_bank[100] == bank_no, 0);
    check("err_done", dn, 0);
    check("err_ready", ready_o, 0);
    check("err_error", error_o, 1);

    run_bank(7, M_TMO, -1, -1, w, dn);
    check("tmo_writes", w, 7);
    check("tmo_done", dn, 0);

    run_bank(9, M_WAIT, -1, -1, w, dn);
    check("wait_writes", w, NW);
    check("wait_done", dn, 1);
    check("wait_error", error_o, 0);
    check("wait_ready", ready_o, 1);

    run_bank(-1, M_ACK, 300, -1, w, dn);
    check("ovr_writes", w, NW);
    check("ovr_done", dn, 1);
    check("ovr_idx", bank_hits(), NW);
    check("ovr_flag", overrun_o, 1);
    enable_i = 1'b0;
    @(negedge clk_i);
    check("ovr_clear", overrun_o, 0);

    run_bank(5, M_BOTH, -1, -1, w, dn);
    check("both_writes", w, 5);
    check("both_idx5", wr_bank[5] == bank_no, 0);
    check("both_error", error_o, 1);

    bank_no++;
    start_bank();
    for (int i = 0; i < 3; i++) begin
      bit stop;
      serve_word(i, M_ACK, 1, 1'b0, stop);
    end
    check("pre_rst_stb", stb_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs",
          {cyc_o, stb_o, we_o, bst_o, busy_o, done_o,
           ready_o, overrun_o, error_o, vis_we_o}, 0);
    check("arst_adr", adr_o, 0);
    check("arst_vis_adr", vis_adr_o, 0);
    @(negedge clk_i);
    rst_n = 1'b1;
    run_bank(-1, M_ACK, -1, -1, w, dn);
    check("post_rst_writes", w, NW);
    check("post_rst_done", dn, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tart_vis_reader.md
# tart_vis_reader

Bus initiator that drains one complete bank of visibilities from the time-multiplexed correlator after each bank switch. It sits in the bus-clock domain between the correlator's Wishbone-like read port and the visibility buffer that the SPI readout logic serves. It walks every valid correlator address in a fixed order, one transfer at a time. Each returned word is written to a linear buffer index. Bus errors, timeouts and missed switches are reported as sticky flags.

## Interface

Parameters:
- `ABITS`, 14: bus address width.
- `BLOCK`, 24: data width of a visibility word.
- `UNITS`, 6: number of correlator units, selected by address bits [9:7].
- `SLOTS`, 12: valid timeslots per pair, address bits [4:1]; slots 12–15 are never addressed.
- `TIMEOUT`, 31: maximum cycles to wait for `ack_i` or `err_i`.
- `DELAY`, 3: simulation-only assignment delay.

Ports:
- `clk_i`, in, 1: bus clock; the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable_i`, in, 1: readout permitted.
- `switch_i`, in, 1: one-cycle bank-switch pulse from the correlator.
- `cyc_o`, out, 1: bus cycle.
- `stb_o`, out, 1: bus strobe.
- `we_o`, out, 1: write enable; constant 0.
- `bst_o`, out, 1: bulk-sequential hint; high while more words remain.
- `adr_o`, out, ABITS: bus address.
- `ack_i`, in, 1: transfer acknowledge.
- `wat_i`, in, 1: responder wait.
- `err_i`, in, 1: responder error.
- `dat_i`, in, BLOCK: read data.
- `vis_we_o`, out, 1: buffer write strobe.
- `vis_adr_o`, out, 10: buffer index.
- `vis_dat_o`, out, BLOCK: buffer write data.
- `busy_o`, out, 1: readout in progress.
- `done_o`, out, 1: one-cycle pulse when a bank completes.
- `ready_o`, out, 1: a complete bank is in the buffer.
- `overrun_o`, out, 1: sticky; a switch arrived while busy.
- `error_o`, out, 1: sticky; readout aborted by an error or timeout.

## Operation

- **Counter fields:** `unit` 0..UNITS-1, `pair` 0..3, `slot` 0..SLOTS-1, `ri` 0..1. The fields increment `ri` fastest, then `slot`, `pair`, `unit`.
- **Address:** `adr_o` = {zeros, unit[2:0], pair[1:0], slot[3:0], ri}.
- **Buffer index:** `vis_adr_o` = unit·96 + pair·24 + slot·2 + ri, maintained as a separate 10-bit incrementer. The last index is 575.
- **IDLE:** all bus outputs are 0.
  - `switch_i && enable_i` zeroes the counters, clears `ready_o` and `error_o`, and enters REQ.
- **REQ:** `cyc_o=stb_o=1`.
  - `err_i` (priority over `ack_i`), or the timeout counter reaching TIMEOUT, goes to IDLE with `error_o=1`, no buffer write and no `done_o`.
  - `ack_i` latches `dat_i` and then:
    - goes to IDLE if this was the last word, or if `enable_i` is low;
    - otherwise goes to GAP.
- **GAP:** `cyc_o=1`, `stb_o=0` for exactly one cycle; the counters advance. Then REQ.
- **Timeout counter:** cleared on entry to REQ, incremented per REQ cycle, held while `wat_i=1`.
- **Switch while busy:** `switch_i` in REQ or GAP sets `overrun_o` and is otherwise ignored. `overrun_o` clears only on reset or `enable_i=0`.
- **`bst_o`:** equals `cyc_o` AND NOT (current word is last).
- **Reset:** every output is 0 and the state is IDLE.

## Timing

- **Start:** `switch_i` sampled at edge 0; at edge 1 `cyc_o=stb_o=1`, `adr_o=0x000`, `busy_o=1`.
- **Per word:** `ack_i` sampled at edge k. At edge k+1:
  - `vis_we_o=1` for one cycle, with `vis_dat_o` = the acked data and `vis_adr_o` = its index;
  - `stb_o=0`.
  At edge k+2 `stb_o=1` with the next address.
- **Throughput:** one word per (responder latency + 2) cycles.
- **Last ack at edge k:** at edge k+1 `vis_we_o=1`, `done_o=1`, `ready_o=1`, `cyc_o=busy_o=0`.
- **Abort at edge k** (`err_i` or timeout): at edge k+1 `cyc_o=stb_o=busy_o=0` and `error_o=1`.
- **Reset mid-transfer:** `rst_n` low clears all outputs immediately, with no clock edge needed; the bus is released at once.

## Test plan

- **Full readout:** `enable_i=1`, one `switch_i` pulse, responder acks 2 cycles after each `stb_o`.
  - Required: 576 `vis_we_o` pulses with `vis_adr_o` 0..575.
  - `adr_o` sequence 0x000, 0x001 … 0x017, 0x020 … 0x077, 0x080 … 0x2F7.
  - `done_o` once; `ready_o=1`; `bst_o=0` on the last transfer only.
- **Bus error:** `err_i` instead of `ack_i` on word 100.
  - Required: 100 buffer writes, none at index 100.
  - `error_o=1`, `cyc_o=0` next cycle, no `done_o`, `ready_o=0`.
- **Timeout and wait:**
  - No response for 32 cycles → abort with `error_o=1`.
  - Repeat with `wat_i=1` for 40 cycles, then `ack_i` → no abort, readout continues.
- **Overrun:** second `switch_i` at word 300.
  - Required: `overrun_o=1`; the sequence completes unchanged to index 575; the readout does not restart.
- **Simultaneous events:** `ack_i` and `err_i` asserted together on word 5 → treated as an error, no write at index 5.
- **Reset:**
  - `rst_n` low mid-REQ → all outputs 0 before the next edge.
  - After release, `switch_i` restarts at `adr_o=0x000`.
